// File: rtl/ysyx_22040365_ifu_pkg.sv
// Shared IFU definitions: state encoding, reset PC, NOP encoding and the alignment helper.
// Optional misaligned-redirect trap is enabled by defining YSYX_22040365_IFU_MISALIGN_CHK_EN.
package ysyx_22040365_ifu_pkg;

  localparam int          DEF_ADDR_W   = 64;
  localparam logic [63:0] DEF_RESET_PC = 64'h0000_0000_8000_0000;
  localparam logic [31:0] NOP_INST     = 32'h0000_0013;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_WAIT = 3'd2,
    ST_HOLD = 3'd3,
    ST_PARK = 3'd4
  } ifu_state_e;

  function automatic logic is_misaligned(input logic [1:0] lsb);
    return (lsb != 2'b00);
  endfunction

endpackage

// File: rtl/ysyx_22040365_pc_reg.sv
// PC register: reset value, +4 step after a fetch, redirect load.
// With YSYX_22040365_IFU_MISALIGN_CHK_EN a misaligned redirect leaves the PC alone and raises a sticky flag.
module ysyx_22040365_pc_reg
  import ysyx_22040365_ifu_pkg::*;
#(
  parameter int               ADDR_W   = DEF_ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = DEF_RESET_PC[ADDR_W-1:0]
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              redirect_en,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              inc_en,
  output logic [ADDR_W-1:0] pc,
  output logic              redirect_bad,
  output logic              misalign
);

  logic [ADDR_W-1:0] pc_r;
  logic [ADDR_W-1:0] target_s;

`ifdef YSYX_22040365_IFU_MISALIGN_CHK_EN
  logic misalign_r;

  assign target_s     = redirect_pc;
  assign redirect_bad = redirect_en & is_misaligned(redirect_pc[1:0]);
  assign misalign     = misalign_r;

  // Sticky flag: every accepted redirect re-evaluates it, so an aligned one clears it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misalign_r <= 1'b0;
    end else if (redirect_en) begin
      misalign_r <= redirect_bad;
    end else begin
      misalign_r <= misalign_r;
    end
  end
`else
  logic unused_lsb_s;

  assign unused_lsb_s = ^redirect_pc[1:0];
  assign target_s     = {redirect_pc[ADDR_W-1:2], 2'b00};
  assign redirect_bad = 1'b0;
  assign misalign     = 1'b0;
`endif

  // Redirect outranks the sequential step; a rejected (misaligned) redirect holds the PC
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_r <= RESET_PC;
    end else if (redirect_en) begin
      pc_r <= redirect_bad ? pc_r : target_s;
    end else if (inc_en) begin
      pc_r <= pc_r + ADDR_W'(4);
    end else begin
      pc_r <= pc_r;
    end
  end

  assign pc = pc_r;

endmodule

// File: rtl/ysyx_22040365_ifu.sv
// Instruction fetch unit: single-outstanding fetch FSM, wrong-path drop flag and one-entry inst buffer.
// Define YSYX_22040365_IFU_MISALIGN_CHK_EN to trap misaligned redirects into a parked state.
module ysyx_22040365_ifu
  import ysyx_22040365_ifu_pkg::*;
#(
  parameter logic [63:0] RESET_PC = DEF_RESET_PC,
  parameter int          ADDR_W   = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              req_valid,
  input  logic              req_ready,
  output logic [ADDR_W-1:0] req_addr,
  input  logic              resp_valid,
  input  logic [31:0]       resp_data,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [31:0]       inst,
  output logic [ADDR_W-1:0] inst_pc,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              ifu_misalign
);

  ifu_state_e        state_r, state_nxt_s;
  logic              drop_r, drop_nxt_s;
  logic [31:0]       inst_r;
  logic [ADDR_W-1:0] inst_pc_r;
  logic [ADDR_W-1:0] pc_s;
  logic              redirect_en_s;
  logic              redirect_bad_s;
  logic              capture_s;

  assign redirect_en_s = redirect_valid & (state_r != ST_IDLE);
  assign capture_s     = (state_r == ST_WAIT) & resp_valid & ~drop_r & ~redirect_en_s;

  ysyx_22040365_pc_reg #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC[ADDR_W-1:0])
  ) u_pc_reg (
    .clk          (clk),
    .rst_n        (rst_n),
    .redirect_en  (redirect_en_s),
    .redirect_pc  (redirect_pc),
    .inc_en       (capture_s),
    .pc           (pc_s),
    .redirect_bad (redirect_bad_s),
    .misalign     (ifu_misalign)
  );

  // State and drop flag register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      drop_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      drop_r  <= drop_nxt_s;
    end
  end

  // Next state; drop marks an accepted request whose response must be thrown away
  always_comb begin
    state_nxt_s = state_r;
    drop_nxt_s  = drop_r;
    case (state_r)
      ST_IDLE: begin
        state_nxt_s = ST_REQ;
      end
      ST_REQ: begin
        if (redirect_en_s) begin
          drop_nxt_s  = req_ready;
          state_nxt_s = redirect_bad_s ? ST_PARK : (req_ready ? ST_WAIT : ST_REQ);
        end else begin
          state_nxt_s = req_ready ? ST_WAIT : ST_REQ;
        end
      end
      ST_WAIT: begin
        if (resp_valid) begin
          drop_nxt_s = 1'b0;
          if (redirect_en_s) begin
            state_nxt_s = redirect_bad_s ? ST_PARK : ST_REQ;
          end else begin
            state_nxt_s = drop_r ? ST_REQ : ST_HOLD;
          end
        end else if (redirect_en_s) begin
          drop_nxt_s  = 1'b1;
          state_nxt_s = redirect_bad_s ? ST_PARK : ST_WAIT;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      ST_HOLD: begin
        if (redirect_en_s) begin
          state_nxt_s = redirect_bad_s ? ST_PARK : ST_REQ;
        end else begin
          state_nxt_s = inst_ready ? ST_REQ : ST_HOLD;
        end
      end
      ST_PARK: begin
        drop_nxt_s = drop_r & ~resp_valid;
        if (redirect_en_s && !redirect_bad_s) begin
          // A request still in flight must be drained before issuing a new one
          state_nxt_s = (drop_r & ~resp_valid) ? ST_WAIT : ST_REQ;
        end else begin
          state_nxt_s = ST_PARK;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        drop_nxt_s  = 1'b0;
      end
    endcase
  end

  // Handshake outputs decoded from the registered state
  always_comb begin
    req_valid  = 1'b0;
    inst_valid = 1'b0;
    case (state_r)
      ST_REQ:  req_valid  = 1'b1;
      ST_HOLD: inst_valid = 1'b1;
      default: begin
        req_valid  = 1'b0;
        inst_valid = 1'b0;
      end
    endcase
  end

  // One-entry instruction buffer, loaded only by a live (non-dropped) response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inst_r    <= NOP_INST;
      inst_pc_r <= '0;
    end else if (capture_s) begin
      inst_r    <= resp_data;
      inst_pc_r <= pc_s;
    end else begin
      inst_r    <= inst_r;
      inst_pc_r <= inst_pc_r;
    end
  end

  assign req_addr = pc_s;
  assign inst     = inst_r;
  assign inst_pc  = inst_pc_r;

endmodule

// File: tb/tb_ysyx_22040365_ifu.sv
// Directed self-checking bench for ysyx_22040365_ifu with a fetch scoreboard.
// Honours YSYX_22040365_IFU_MISALIGN_CHK_EN for the misaligned-redirect step.
module tb_ysyx_22040365_ifu;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] data;
  } fetch_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid;
  logic        req_ready = 1'b0;
  logic [63:0] req_addr;
  logic        resp_valid = 1'b0;
  logic [31:0] resp_data = 32'h0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst;
  logic [63:0] inst_pc;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = 64'h0;
  logic        ifu_misalign;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [63:0] model_pc;
  fetch_t      sb_q[$];

  ysyx_22040365_ifu dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_addr       (req_addr),
    .resp_valid     (resp_valid),
    .resp_data      (resp_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .ifu_misalign   (ifu_misalign)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_req(input string tag);
    for (int i = 0; i < 20 && req_valid !== 1'b1; i++) tick();
    chk({tag, "_req_valid"}, {63'd0, req_valid}, 64'd1);
    chk({tag, "_req_addr"}, req_addr, model_pc);
  endtask

  task automatic do_fetch(input string tag, input logic [31:0] data);
    fetch_t e;
    wait_req(tag);
    req_ready = 1'b1;
    tick();
    req_ready  = 1'b0;
    resp_valid = 1'b1;
    resp_data  = data;
    e.pc = model_pc;
    e.data = data;
    sb_q.push_back(e);
    tick();
    resp_valid = 1'b0;
    model_pc   = model_pc + 64'd4;
  endtask

  task automatic consume(input string tag);
    fetch_t e;
    chk({tag, "_inst_valid"}, {63'd0, inst_valid}, 64'd1);
    if (sb_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $error("FAIL %s_sb_empty: observed 0 entries expected 1", tag);
    end else begin
      e = sb_q.pop_front();
      chk({tag, "_inst"}, {32'd0, inst}, {32'd0, e.data});
      chk({tag, "_inst_pc"}, inst_pc, e.pc);
    end
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    chk({tag, "_next_req_valid"}, {63'd0, req_valid}, 64'd1);
    chk({tag, "_next_req_addr"}, req_addr, model_pc);
  endtask

  task automatic redirect(input logic [63:0] tgt);
    redirect_valid = 1'b1;
    redirect_pc    = tgt;
    tick();
    redirect_valid = 1'b0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_req_valid"}, {63'd0, req_valid}, 64'd0);
    chk({tag, "_inst_valid"}, {63'd0, inst_valid}, 64'd0);
    chk({tag, "_inst"}, {32'd0, inst}, 64'h0000_0000_0000_0013);
    chk({tag, "_inst_pc"}, inst_pc, 64'd0);
    chk({tag, "_misalign"}, {63'd0, ifu_misalign}, 64'd0);
    chk({tag, "_addr"}, req_addr, 64'h0000_0000_8000_0000);
  endtask

  initial begin
    model_pc = 64'h0000_0000_8000_0000;
    tick();
    chk_reset("rst");
    rst_n = 1'b1;

    // 1: first fetch and handoff
    do_fetch("t1", 32'h0050_0093);
    consume("t1");

    // 2: decode stall holds buffer
    do_fetch("t2", 32'h0010_0113);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t2_hold_valid", {63'd0, inst_valid}, 64'd1);
      chk("t2_hold_inst", {32'd0, inst}, 64'h0000_0000_0010_0113);
      chk("t2_hold_pc", inst_pc, 64'h0000_0000_8000_0004);
      chk("t2_hold_noreq", {63'd0, req_valid}, 64'd0);
    end
    consume("t2");

    // 3: memory back-pressure, then redirect before accept
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t3_held_valid", {63'd0, req_valid}, 64'd1);
      chk("t3_held_addr", req_addr, 64'h0000_0000_8000_0008);
    end
    redirect(64'h0000_0000_8000_0100);
    model_pc = 64'h0000_0000_8000_0100;
    chk("t3_redir_valid", {63'd0, req_valid}, 64'd1);
    chk("t3_redir_addr", req_addr, model_pc);

    // 4: redirect in WAIT drops the late response
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0;
    redirect(64'h0000_0000_8000_0200);
    model_pc = 64'h0000_0000_8000_0200;
    tick();
    resp_valid = 1'b1;
    resp_data  = 32'hDEAD_BEEF;
    tick();
    resp_valid = 1'b0;
    chk("t4_no_inst", {63'd0, inst_valid}, 64'd0);
    chk("t4_req_valid", {63'd0, req_valid}, 64'd1);
    chk("t4_req_addr", req_addr, model_pc);
    do_fetch("t4b", 32'h0000_0513);
    consume("t4b");

    // 5: redirect coincident with response, then reset in WAIT
    req_ready = 1'b1;
    tick();
    req_ready      = 1'b0;
    resp_valid     = 1'b1;
    resp_data      = 32'h1111_1111;
    redirect(64'h0000_0000_8000_0300);
    resp_valid = 1'b0;
    model_pc = 64'h0000_0000_8000_0300;
    chk("t5_no_inst", {63'd0, inst_valid}, 64'd0);
    chk("t5_req_valid", {63'd0, req_valid}, 64'd1);
    chk("t5_req_addr", req_addr, model_pc);
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_reset("t5_rst");
    resp_valid = 1'b1;
    resp_data  = 32'h2222_2222;
    tick();
    resp_valid = 1'b0;
    rst_n = 1'b1;
    model_pc = 64'h0000_0000_8000_0000;
    chk("t5_idle_no_inst", {63'd0, inst_valid}, 64'd0);
    do_fetch("t5r", 32'h0030_0193);
    consume("t5r");

    // PC wrap at the top of the address space
    redirect(64'hFFFF_FFFF_FFFF_FFFC);
    model_pc = 64'hFFFF_FFFF_FFFF_FFFC;
    do_fetch("wrap", 32'h0040_0213);
    consume("wrap");
    chk("wrap_zero", req_addr, 64'd0);

    // 6: misaligned redirect
    redirect(64'h0000_0000_8000_0102);
`ifdef YSYX_22040365_IFU_MISALIGN_CHK_EN
    for (int i = 0; i < 3; i++) begin
      chk("t6_flag", {63'd0, ifu_misalign}, 64'd1);
      chk("t6_noreq", {63'd0, req_valid}, 64'd0);
      chk("t6_noinst", {63'd0, inst_valid}, 64'd0);
      tick();
    end
    redirect(64'h0000_0000_8000_0104);
    chk("t6_flag_clr", {63'd0, ifu_misalign}, 64'd0);
    chk("t6_resume_valid", {63'd0, req_valid}, 64'd1);
    chk("t6_resume_addr", req_addr, 64'h0000_0000_8000_0104);
`else
    chk("t6_flag", {63'd0, ifu_misalign}, 64'd0);
    chk("t6_req_valid", {63'd0, req_valid}, 64'd1);
    chk("t6_req_addr", req_addr, 64'h0000_0000_8000_0100);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
